// File: rtl/i2c_pkg.sv
// Shared types for the EDID/DDC I2C target: FSM states, pointer width, debug view.
package i2c_pkg;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
    localparam int         EDID_SIZE    = 256;
    localparam int         PTR_W        = $clog2(EDID_SIZE);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEV     = 4'd1,
        S_DEV_ACK = 4'd2,
        S_REG     = 4'd3,
        S_REG_ACK = 4'd4,
        S_WR      = 4'd5,
        S_WR_ACK  = 4'd6,
        S_RD      = 4'd7,
        S_RD_ACK  = 4'd8
    } state_e;

    typedef struct packed {
        state_e             state;
        logic [PTR_W-1:0]   ptr;
        logic [2:0]         bit_cnt;
    } dbg_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus N-sample glitch filter for one I2C line, with edge pulses.
module i2c_line_filter #(
    parameter int P_FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [2:0] cnt_q, cnt_d;

    // The level flips only after P_FILT consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = 3'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == 3'(P_FILT - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
        rise_d = ~level_q & level_d;
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= 3'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= i_line;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/i2c_edid_slave.sv
// I2C target emulating a 256-byte EDID EEPROM backed by an external registered-output RAM.
module i2c_edid_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] P_DEV_ADDR = DEF_DEV_ADDR,
    parameter int         P_FILT     = 3,
    parameter int         P_SDA_HOLD = 8
) (
    input  logic             i_local_clk,
    input  logic             i_rst_n,
    input  logic             i_scl,
    input  logic             i_sda,
    output logic             o_sda,
    output logic [PTR_W-1:0] o_mem_addr,
    output logic             o_mem_wr,
    output logic [7:0]       o_mem_wdata,
    input  logic [7:0]       i_mem_rdata,
    output logic             o_busy,
    output logic             o_start_det,
    output logic             o_stop_det,
    output dbg_t             o_dbg
);

    localparam int HOLD_W = $clog2(P_SDA_HOLD + 1);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_filter #(.P_FILT(P_FILT)) u_scl_filt (
        .clk(i_local_clk), .rst_n(i_rst_n), .i_line(i_scl),
        .o_level(scl_f), .o_rise(scl_rise), .o_fall(scl_fall)
    );

    i2c_line_filter #(.P_FILT(P_FILT)) u_sda_filt (
        .clk(i_local_clk), .rst_n(i_rst_n), .i_line(i_sda),
        .o_level(sda_f), .o_rise(sda_rise), .o_fall(sda_fall)
    );

    assign start = sda_fall & scl_f;
    assign stop  = sda_rise & scl_f;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         tx_q, tx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               tgt_q, tgt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               sda_q, sda_d;
    logic [PTR_W-1:0]   mem_addr_q, mem_addr_d;
    logic               mem_wr_q, mem_wr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               fetch_q, fetch_d;
    logic               load_q, load_d;
    logic               inc_q, inc_d;
    logic               busy_q, busy_d;
    logic               start_det_q, start_det_d;
    logic               stop_det_q, stop_det_d;
    logic [7:0]         rx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        tgt_d       = tgt_q;
        hold_d      = hold_q;
        sda_d       = sda_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        fetch_d     = 1'b0;
        load_d      = fetch_q;
        inc_d       = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        rx          = {shift_q[6:0], sda_f};

        if (load_q) tx_d = i_mem_rdata;
        if (inc_q)  ptr_d = ptr_q + PTR_W'(1);

        // A pending SDA change is abandoned if SCL is already high again.
        if (hold_q != '0) begin
            hold_d = scl_f ? '0 : hold_q - HOLD_W'(1);
            if (!scl_f && hold_q == HOLD_W'(1)) sda_d = tgt_q;
        end

        if (start) begin
            state_d     = S_DEV;
            cnt_d       = 3'd0;
            sda_d       = 1'b1;
            tgt_d       = 1'b1;
            hold_d      = '0;
            start_det_d = 1'b1;
        end else if (stop) begin
            state_d    = S_IDLE;
            cnt_d      = 3'd0;
            sda_d      = 1'b1;
            tgt_d      = 1'b1;
            hold_d     = '0;
            stop_det_d = 1'b1;
        end else if (scl_fall) begin
            hold_d = HOLD_W'(P_SDA_HOLD);
            case (state_q)
                S_DEV_ACK, S_REG_ACK, S_WR_ACK: tgt_d = 1'b0;
                S_RD:                           tgt_d = tx_q[3'd7 - cnt_q];
                default:                        tgt_d = 1'b1;
            endcase
            // Data is committed only once the ACK slot opens, so a STOP right after the 8th bit writes nothing.
            if (state_q == S_WR_ACK) begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = ptr_q;
                mem_wdata_d = shift_q;
                inc_d       = 1'b1;
            end
        end else if (scl_rise) begin
            case (state_q)
                S_DEV, S_REG, S_WR: begin
                    shift_d = rx;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d = 3'd0;
                        if (state_q == S_DEV) begin
                            state_d = (rx[7:1] == P_DEV_ADDR) ? S_DEV_ACK : S_IDLE;
                        end else if (state_q == S_REG) begin
                            ptr_d   = rx;
                            state_d = S_REG_ACK;
                        end else begin
                            state_d = S_WR_ACK;
                        end
                    end
                end
                S_DEV_ACK: begin
                    cnt_d = 3'd0;
                    if (shift_q[0]) begin
                        state_d    = S_RD;
                        mem_addr_d = ptr_q;
                        fetch_d    = 1'b1;
                    end else begin
                        state_d = S_REG;
                    end
                end
                S_REG_ACK, S_WR_ACK: begin
                    state_d = S_WR;
                    cnt_d   = 3'd0;
                end
                S_RD: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cnt_d   = 3'd0;
                        state_d = S_RD_ACK;
                    end
                end
                S_RD_ACK: begin
                    ptr_d = ptr_q + PTR_W'(1);
                    cnt_d = 3'd0;
                    if (!sda_f) begin
                        state_d    = S_RD;
                        mem_addr_d = ptr_q + PTR_W'(1);
                        fetch_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DEV);
    end

    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 8'd0;
            ptr_q       <= '0;
            tgt_q       <= 1'b1;
            hold_q      <= '0;
            sda_q       <= 1'b1;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
            fetch_q     <= 1'b0;
            load_q      <= 1'b0;
            inc_q       <= 1'b0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            tgt_q       <= tgt_d;
            hold_q      <= hold_d;
            sda_q       <= sda_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            fetch_q     <= fetch_d;
            load_q      <= load_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign o_sda         = sda_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wr      = mem_wr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_busy        = busy_q;
    assign o_start_det   = start_det_q;
    assign o_stop_det    = stop_det_q;
    assign o_dbg.state   = state_q;
    assign o_dbg.ptr     = ptr_q;
    assign o_dbg.bit_cnt = cnt_q;

endmodule

// File: tb/tb_i2c_edid_slave.sv
// Bench for i2c_edid_slave: behavioural I2C master, registered RAM model and scoreboards.
module tb_i2c_edid_slave;
    import i2c_pkg::*;

    localparam logic [6:0] DEV = 7'h50;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       bus_sda;
    logic       o_sda, o_mem_wr, o_busy, o_start_det, o_stop_det;
    logic [7:0] o_mem_addr, o_mem_wdata;
    logic [7:0] mem_rdata;
    dbg_t       dbg;

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  wdat    [256];
    logic [15:0] wr_exp_q[$];
    logic [7:0]  rd_exp_q[$];
    logic [15:0] wr_exp;
    logic [7:0]  ptr_m = 8'd0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    logic        busy_seen = 1'b0;

    assign bus_sda = sda_m & o_sda;

    always #5 clk = ~clk;

    i2c_edid_slave #(.P_DEV_ADDR(DEV), .P_FILT(3), .P_SDA_HOLD(2)) dut (
        .i_local_clk(clk), .i_rst_n(rst_n), .i_scl(scl_m), .i_sda(bus_sda),
        .o_sda(o_sda), .o_mem_addr(o_mem_addr), .o_mem_wr(o_mem_wr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(o_busy),
        .o_start_det(o_start_det), .o_stop_det(o_stop_det), .o_dbg(dbg)
    );

    always @(posedge clk) begin
        if (o_mem_wr) ram[o_mem_addr] = o_mem_wdata;
        mem_rdata <= ram[o_mem_addr];
    end

    // Write scoreboard and event counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_start_det) start_cnt++;
            if (o_stop_det)  stop_cnt++;
            if (o_busy)      busy_seen = 1'b1;
            if (o_mem_wr) begin
                n_checks++;
                if (wr_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write addr=%h data=%h", o_mem_addr, o_mem_wdata);
                end else begin
                    wr_exp = wr_exp_q.pop_front();
                    if ({o_mem_addr, o_mem_wdata} !== wr_exp) begin
                        n_fail++;
                        $display("FAIL mem_write got=%h exp=%h", {o_mem_addr, o_mem_wdata}, wr_exp);
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clks(10);
        scl_m = 1'b1; wait_clks(6);
        sda_m = 1'b0; wait_clks(6);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clks(3); sda_m = 1'b0;
        wait_clks(7); scl_m = 1'b1;
        wait_clks(6); sda_m = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic r);
        wait_clks(3); sda_m = b;
        wait_clks(7); scl_m = 1'b1;
        wait_clks(3); r = bus_sda;
        if (glitch) begin
            sda_m = ~b; wait_clks(1); sda_m = b; wait_clks(2);
        end else begin
            wait_clks(3);
        end
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_idx, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_idx == i, r);
        send_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        send_bit(nack, 1'b0, r);
    endtask

    task automatic wr_txn(input logic [7:0] reg_a, input int n, input int g_byte, input int g_bit,
                          input string tag);
        logic ack;
        bus_start();
        write_byte({DEV, 1'b0}, -1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_dev_ack got=%b exp=1", tag, ack); end
        write_byte(reg_a, -1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_reg_ack got=%b exp=1", tag, ack); end
        ptr_m = reg_a;
        for (int i = 0; i < n; i++) begin
            wr_exp_q.push_back({ptr_m, wdat[i]});
            write_byte(wdat[i], (i == g_byte) ? g_bit : -1, ack);
            n_checks++;
            if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_data_ack byte=%0d got=%b exp=1", tag, i, ack); end
            ref_mem[ptr_m] = wdat[i];
            ptr_m++;
        end
        bus_stop();
    endtask

    task automatic rd_bytes(input int n, input string tag);
        logic [7:0] d, e;
        for (int i = 0; i < n; i++) begin
            rd_exp_q.push_back(ref_mem[ptr_m]);
            read_byte(i == n - 1, d);
            e = rd_exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL %s_rdata byte=%0d got=%h exp=%h", tag, i, d, e); end
            ptr_m++;
        end
        bus_stop();
    endtask

    task automatic rd_random(input logic [7:0] reg_a, input int n, input string tag);
        logic ack;
        bus_start();
        write_byte({DEV, 1'b0}, -1, ack);
        write_byte(reg_a, -1, ack);
        ptr_m = reg_a;
        bus_start();
        write_byte({DEV, 1'b1}, -1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_rd_dev_ack got=%b exp=1", tag, ack); end
        rd_bytes(n, tag);
    endtask

    task automatic test_reset();
        wait_clks(4);
        n_checks++;
        if ({o_sda, o_mem_wr, o_busy, o_start_det, o_stop_det} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=10000", {o_sda, o_mem_wr, o_busy, o_start_det, o_stop_det});
        end
        n_checks++;
        if ({o_mem_addr, o_mem_wdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mem got=%h exp=0000", {o_mem_addr, o_mem_wdata});
        end
        n_checks++;
        if (dbg.state !== S_IDLE || dbg.ptr !== 8'h00) begin
            n_fail++; $display("FAIL reset_state got=%0d/%h exp=0/00", dbg.state, dbg.ptr);
        end
        rst_n = 1'b1;
        wait_clks(10);
        n_checks++;
        if (o_sda !== 1'b1 || start_cnt != 0 || stop_cnt != 0) begin
            n_fail++; $display("FAIL reset_idle got=%b/%0d/%0d exp=1/0/0", o_sda, start_cnt, stop_cnt);
        end
    endtask

    task automatic test_write();
        int s0, p0;
        s0 = start_cnt; p0 = stop_cnt; busy_seen = 1'b0;
        wdat[0] = 8'hA5; wdat[1] = 8'h3C;
        wr_txn(8'h10, 2, -1, -1, "write");
        n_checks++;
        if (ram[8'h10] !== 8'hA5 || ram[8'h11] !== 8'h3C) begin
            n_fail++; $display("FAIL write_ram got=%h%h exp=a53c", ram[8'h10], ram[8'h11]);
        end
        n_checks++;
        if (dbg.ptr !== 8'h12) begin n_fail++; $display("FAIL write_ptr got=%h exp=12", dbg.ptr); end
        n_checks++;
        if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            n_fail++; $display("FAIL write_events got=%0d/%0d exp=1/1", start_cnt - s0, stop_cnt - p0);
        end
        n_checks++;
        if (busy_seen !== 1'b1 || o_busy !== 1'b0 || dbg.state !== S_IDLE) begin
            n_fail++; $display("FAIL write_busy got=%b/%b/%0d exp=1/0/0", busy_seen, o_busy, dbg.state);
        end
    endtask

    task automatic test_random_read();
        int s0;
        for (int i = 0; i < 4; i++) begin
            ram[8'h20 + i] = 8'h90 + 8'(i * 7);
            ref_mem[8'h20 + i] = 8'h90 + 8'(i * 7);
        end
        s0 = start_cnt;
        rd_random(8'h20, 4, "rread");
        n_checks++;
        if (dbg.ptr !== 8'h24) begin n_fail++; $display("FAIL rread_ptr got=%h exp=24", dbg.ptr); end
        n_checks++;
        if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL rread_starts got=%0d exp=2", start_cnt - s0); end
    endtask

    task automatic test_bad_addr();
        logic ack;
        busy_seen = 1'b0;
        bus_start();
        write_byte({7'h51, 1'b0}, -1, ack);
        bus_stop();
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL badaddr_ack got=%b exp=0", ack); end
        n_checks++;
        if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL badaddr_busy got=%b exp=0", busy_seen); end
        n_checks++;
        if (dbg.state !== S_IDLE || dbg.ptr !== ptr_m) begin
            n_fail++; $display("FAIL badaddr_state got=%0d/%h exp=0/%h", dbg.state, dbg.ptr, ptr_m);
        end
    endtask

    task automatic test_stop_mid_byte();
        logic ack, r;
        bus_start();
        write_byte({DEV, 1'b0}, -1, ack);
        write_byte(8'h40, -1, ack);
        ptr_m = 8'h40;
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, r);
        bus_stop();
        n_checks++;
        if (o_sda !== 1'b1 || dbg.state !== S_IDLE || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL stopmid_idle got=%b/%0d/%b exp=1/0/0", o_sda, dbg.state, o_busy);
        end
        n_checks++;
        if (dbg.ptr !== 8'h40) begin n_fail++; $display("FAIL stopmid_ptr got=%h exp=40", dbg.ptr); end
        wdat[0] = 8'h77;
        wr_txn(8'h41, 1, -1, -1, "stopmid_next");
        n_checks++;
        if (ram[8'h41] !== 8'h77) begin n_fail++; $display("FAIL stopmid_next_ram got=%h exp=77", ram[8'h41]); end
    endtask

    task automatic test_glitch();
        int s0, p0;
        s0 = start_cnt; p0 = stop_cnt;
        wdat[0] = 8'hC3;
        wr_txn(8'h60, 1, 0, 7, "glitch_lo");
        wdat[0] = 8'h3C;
        wr_txn(8'h61, 1, 0, 7, "glitch_hi");
        n_checks++;
        if (start_cnt - s0 != 2 || stop_cnt - p0 != 2) begin
            n_fail++; $display("FAIL glitch_events got=%0d/%0d exp=2/2", start_cnt - s0, stop_cnt - p0);
        end
        n_checks++;
        if (ram[8'h60] !== 8'hC3 || ram[8'h61] !== 8'h3C) begin
            n_fail++; $display("FAIL glitch_ram got=%h%h exp=c33c", ram[8'h60], ram[8'h61]);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) wdat[i] = 8'($urandom_range(0, 255));
        wr_txn(8'hFF, 256, -1, -1, "wrap");
        n_checks++;
        if (ram[8'hFF] !== wdat[0] || ram[8'h00] !== wdat[1] || ram[8'hFE] !== wdat[255]) begin
            n_fail++; $display("FAIL wrap_ram got=%h/%h/%h exp=%h/%h/%h",
                               ram[8'hFF], ram[8'h00], ram[8'hFE], wdat[0], wdat[1], wdat[255]);
        end
        n_checks++;
        if (dbg.ptr !== 8'hFF) begin n_fail++; $display("FAIL wrap_wr_ptr got=%h exp=ff", dbg.ptr); end
        rd_random(8'hFF, 256, "wrap");
        n_checks++;
        if (dbg.ptr !== ptr_m) begin n_fail++; $display("FAIL wrap_rd_ptr got=%h exp=%h", dbg.ptr, ptr_m); end
    endtask

    task automatic test_reset_mid_read();
        logic ack, r;
        ram[ptr_m] = 8'h00;
        ref_mem[ptr_m] = 8'h00;
        bus_start();
        write_byte({DEV, 1'b1}, -1, ack);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, r);
        wait_clks(10);
        n_checks++;
        if (o_sda !== 1'b0) begin n_fail++; $display("FAIL rstmid_driving got=%b exp=0", o_sda); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_sda got=%b exp=1", o_sda); end
        n_checks++;
        if (dbg.ptr !== 8'h00 || dbg.state !== S_IDLE) begin
            n_fail++; $display("FAIL rstmid_state got=%h/%0d exp=00/0", dbg.ptr, dbg.state);
        end
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        ptr_m = 8'h00;
        wait_clks(5);
        bus_start();
        write_byte({DEV, 1'b1}, -1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_recover_ack got=%b exp=1", ack); end
        rd_bytes(1, "rstmid_recover");
        n_checks++;
        if (dbg.ptr !== 8'h01) begin n_fail++; $display("FAIL rstmid_recover_ptr got=%h exp=01", dbg.ptr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_write();
        test_random_read();
        test_bad_addr();
        test_stop_mid_byte();
        test_glitch();
        test_wrap();
        test_reset_mid_read();
        wait_clks(20);
        n_checks++;
        if (wr_exp_q.size() != 0) begin
            n_fail++; $display("FAIL pending_writes got=%0d exp=0", wr_exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
